// File: rtl/mux_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_bus_arbiter_if
// Bundle of request, data and gated-bus signals shared by the round-robin
// arbiter and the sources/consumer around it.
//   req       : per-source level-sensitive bus request
//   data_in   : packed source data, source i at [i*WIDTH +: WIDTH]
//   grant     : one-hot (or zero) select bits for the gating muxes
//   bus_out   : OR-combined gated bus value
//   bus_valid : high while any grant bit is high
//   busy      : high while the arbiter is holding a grant or in the gap
// Modports:
//   master : the arbiter (drives grant and the bus outputs)
//   slave  : the sources/consumer side (drives req and data_in)
// ---------------------------------------------------------------------------
interface mux_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic                     busy;

  modport master (
    input  req,
    input  data_in,
    output grant,
    output bus_out,
    output bus_valid,
    output busy
  );

  modport slave (
    output req,
    output data_in,
    input  grant,
    input  bus_out,
    input  bus_valid,
    input  busy
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mux_bus_arbiter
// Round-robin arbiter for a shared result bus built from per-source gating
// muxes. A grant is held for at most HOLD_CYCLES cycles (or until the owner
// drops its request), followed by a one-cycle gap and one idle cycle before
// the next arbitration. The gated bus value is formed combinationally.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : asynchronous, active-high reset
//   bus     : mux_bus_arbiter_if master modport (req, data_in in;
//             grant, bus_out, bus_valid, busy out)
// ---------------------------------------------------------------------------
module mux_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mux_bus_arbiter_if.master    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_nextGrant;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     w_nextLast;
  logic [CNT_W-1:0]     r_holdCnt;
  logic [CNT_W-1:0]     w_nextHoldCnt;
  logic [IDX_W-1:0]     w_pickIdx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_pickValid;
  logic [WIDTH-1:0]     w_busOr;

  // Round-robin search starting just after the last owner. The loop runs
  // from the farthest candidate back to the nearest so the nearest
  // requesting index is the one left in w_pickIdx.
  always_comb begin
    w_pickValid = 1'b0;
    w_pickIdx   = '0;
    w_cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (bus.req[w_cand]) begin
        w_pickValid = 1'b1;
        w_pickIdx   = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_holdCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_grant   <= w_nextGrant;
      r_last    <= w_nextLast;
      r_holdCnt <= w_nextHoldCnt;
    end
  end

  // While in HOLD, r_last is the current owner, so its request bit decides
  // early release. Other requests are ignored until the next IDLE cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextGrant   = r_grant;
    w_nextLast    = r_last;
    w_nextHoldCnt = r_holdCnt;
    case (r_state)
      IDLE: begin
        w_nextGrant = '0;
        if (w_pickValid) begin
          w_nextGrant[w_pickIdx] = 1'b1;
          w_nextLast             = w_pickIdx;
          w_nextHoldCnt          = CNT_W'(1);
          w_nextState            = HOLD;
        end
      end
      HOLD: begin
        if (!bus.req[r_last] || (r_holdCnt == CNT_W'(HOLD_CYCLES))) begin
          w_nextGrant   = '0;
          w_nextHoldCnt = '0;
          w_nextState   = GAP;
        end else begin
          w_nextHoldCnt = r_holdCnt + CNT_W'(1);
        end
      end
      GAP: begin
        w_nextGrant = '0;
        w_nextState = IDLE;
      end
      default: begin
        w_nextGrant   = '0;
        w_nextHoldCnt = '0;
        w_nextState   = IDLE;
      end
    endcase
  end

  // Each gating mux passes its source only when selected; with a one-hot
  // grant the OR simply yields the owner's data, or zero when idle.
  always_comb begin
    w_busOr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_busOr = w_busOr | bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.bus_out   = w_busOr;
  assign bus.bus_valid = |r_grant;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_bus_arbiter
// Self-checking bench for mux_bus_arbiter. A behavioural model tracks the
// current owner, how long it has owned the bus and how many cool-down edges
// remain before the next arbitration; expected outputs are derived from it
// and from fixed sequences for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_mux_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 3;
  localparam int HOLD    = 2;

  logic clk;
  logic reset;

  mux_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) busIf ();

  mux_bus_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount;
  int failCount;

  int mOwner;
  int mOwned;
  int mCool;
  int mLast;

  logic [NUM_REQ-1:0] rotExp [17];

  function automatic void modelReset();
    mOwner = -1;
    mOwned = 0;
    mCool  = 0;
    mLast  = NUM_REQ - 1;
  endfunction

  // Advance the model by one clock edge using the request vector sampled
  // at that edge.
  function automatic void modelStep(input logic [NUM_REQ-1:0] r);
    if (mOwner >= 0) begin
      if (!r[mOwner] || mOwned == HOLD) begin
        mOwner = -1;
        mCool  = 1;
      end else begin
        mOwned++;
      end
    end else if (mCool > 0) begin
      mCool--;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (mLast + k) % NUM_REQ;
        if (r[c]) begin
          mOwner = c;
          mLast  = c;
          mOwned = 1;
          break;
        end
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] expGrant();
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (mOwner >= 0) g[mOwner] = 1'b1;
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] expBus();
    if (mOwner >= 0) return busIf.data_in[mOwner*WIDTH +: WIDTH];
    return '0;
  endfunction

  function automatic logic expBusy();
    return (mOwner >= 0) || (mCool > 0);
  endfunction

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r,
                               input logic [NUM_REQ*WIDTH-1:0] d);
    busIf.req     = r;
    busIf.data_in = d;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus('0, '1);
    reset = 1'b1;
    modelReset();
    #1;
    checkCount++;
    if (busIf.grant !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_grant: got %b expected %b", busIf.grant, 4'b0000);
    end
    checkCount++;
    if (busIf.bus_out !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_bus: got %b expected %b", busIf.bus_out, 3'b000);
    end
    checkCount++;
    if (busIf.bus_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_valid: got %b expected 0", busIf.bus_valid);
    end
    checkCount++;
    if (busIf.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busIf.busy);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_idle_gating();
    applyStimulus('0, '1);
    for (int i = 0; i < 6; i++) begin
      modelStep(busIf.req);
      @(posedge clk);
      #1;
      checkCount++;
      if (busIf.bus_out !== 3'b000 || busIf.bus_valid !== 1'b0 ||
          busIf.busy !== 1'b0 || busIf.grant !== 4'b0000) begin
        failCount++;
        $display("[TB] FAIL idle_gating cycle %0d: bus=%b valid=%b busy=%b grant=%b expected 000/0/0/0000",
                 i, busIf.bus_out, busIf.bus_valid, busIf.busy, busIf.grant);
      end
    end
  endtask

  task automatic test_single_source();
    logic [NUM_REQ-1:0] gExp [6];
    logic [WIDTH-1:0]   bExp [6];
    gExp = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    bExp = '{3'b101, 3'b101, 3'b000, 3'b000, 3'b101, 3'b101};
    applyReset();
    applyStimulus(4'b0100, {3'b110, 3'b101, 3'b011, 3'b111});
    for (int i = 0; i < 6; i++) begin
      modelStep(busIf.req);
      @(posedge clk);
      #1;
      checkCount++;
      if (busIf.grant !== gExp[i] || busIf.bus_out !== bExp[i] ||
          busIf.bus_valid !== (gExp[i] != 0)) begin
        failCount++;
        $display("[TB] FAIL single_source cycle %0d: grant=%b bus=%b valid=%b expected %b/%b/%b",
                 i, busIf.grant, busIf.bus_out, busIf.bus_valid, gExp[i], bExp[i], gExp[i] != 0);
      end
      if (i == 0) begin
        busIf.data_in[8:6] = 3'b010;
        #1;
        checkCount++;
        if (busIf.bus_out !== 3'b010) begin
          failCount++;
          $display("[TB] FAIL bus_follow: got %b expected %b", busIf.bus_out, 3'b010);
        end
        busIf.data_in[8:6] = 3'b101;
      end
    end
  endtask

  task automatic test_rotation();
    rotExp = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
               4'b0010, 4'b0010, 4'b0000, 4'b0000,
               4'b0100, 4'b0100, 4'b0000, 4'b0000,
               4'b1000, 4'b1000, 4'b0000, 4'b0000,
               4'b0001};
    applyReset();
    applyStimulus(4'b1111, 12'($urandom));
    for (int i = 0; i < 17; i++) begin
      modelStep(busIf.req);
      @(posedge clk);
      #1;
      checkCount++;
      if (busIf.grant !== rotExp[i] || busIf.bus_out !== expBus()) begin
        failCount++;
        $display("[TB] FAIL rotation cycle %0d: grant=%b bus=%b expected %b/%b",
                 i, busIf.grant, busIf.bus_out, rotExp[i], expBus());
      end
    end
  endtask

  task automatic test_wrap();
    applyReset();
    applyStimulus(4'b1001, 12'($urandom));
    for (int i = 0; i < 14; i++) begin
      modelStep(busIf.req);
      @(posedge clk);
      #1;
      checkCount++;
      if (busIf.grant !== expGrant() || busIf.grant[2:1] !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL wrap cycle %0d: grant=%b expected %b", i, busIf.grant, expGrant());
      end
      if (i == 0 || i == 4 || i == 8) begin
        checkCount++;
        if (busIf.grant !== ((i == 4) ? 4'b1000 : 4'b0001)) begin
          failCount++;
          $display("[TB] FAIL wrap_order cycle %0d: grant=%b expected %b",
                   i, busIf.grant, (i == 4) ? 4'b1000 : 4'b0001);
        end
      end
    end
  endtask

  task automatic test_early_release();
    logic [NUM_REQ-1:0] reqSeq  [4];
    logic [NUM_REQ-1:0] gExp    [4];
    logic               busyExp [4];
    reqSeq  = '{4'b0010, 4'b0000, 4'b0110, 4'b0110};
    gExp    = '{4'b0010, 4'b0000, 4'b0000, 4'b0100};
    busyExp = '{1'b1, 1'b1, 1'b0, 1'b1};
    applyReset();
    busIf.data_in = 12'($urandom);
    for (int i = 0; i < 4; i++) begin
      busIf.req = reqSeq[i];
      modelStep(busIf.req);
      @(posedge clk);
      #1;
      checkCount++;
      if (busIf.grant !== gExp[i] || busIf.busy !== busyExp[i] ||
          busIf.grant !== expGrant()) begin
        failCount++;
        $display("[TB] FAIL early_release cycle %0d: grant=%b busy=%b expected %b/%b",
                 i, busIf.grant, busIf.busy, gExp[i], busyExp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    applyReset();
    applyStimulus(4'b0010, {3'b000, 3'b000, 3'b111, 3'b000});
    modelStep(busIf.req);
    @(posedge clk);
    #1;
    checkCount++;
    if (busIf.grant !== 4'b0010 || busIf.bus_out !== 3'b111) begin
      failCount++;
      $display("[TB] FAIL pre_reset_grant: grant=%b bus=%b expected 0010/111",
               busIf.grant, busIf.bus_out);
    end
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkCount++;
    if (busIf.grant !== 4'b0000 || busIf.bus_out !== 3'b000 ||
        busIf.bus_valid !== 1'b0 || busIf.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: grant=%b bus=%b valid=%b busy=%b expected all zero",
               busIf.grant, busIf.bus_out, busIf.bus_valid, busIf.busy);
    end
    busIf.req = 4'b0011;
    @(posedge clk);
    #2;
    reset = 1'b0;
    modelStep(busIf.req);
    @(posedge clk);
    #1;
    checkCount++;
    if (busIf.grant !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL post_reset_first: grant=%b expected 0001", busIf.grant);
    end
  endtask

  task automatic test_random();
    applyReset();
    applyStimulus(4'($urandom), 12'($urandom));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) busIf.req = 4'($urandom);
      busIf.data_in = 12'($urandom);
      modelStep(busIf.req);
      @(posedge clk);
      #1;
      checkCount++;
      if (busIf.grant !== expGrant() || busIf.bus_out !== expBus() ||
          busIf.bus_valid !== (mOwner >= 0) || busIf.busy !== expBusy() ||
          !$onehot0(busIf.grant)) begin
        failCount++;
        $display("[TB] FAIL random cycle %0d: grant=%b bus=%b valid=%b busy=%b expected %b/%b/%b/%b",
                 i, busIf.grant, busIf.bus_out, busIf.bus_valid, busIf.busy,
                 expGrant(), expBus(), mOwner >= 0, expBusy());
      end
      busIf.data_in = 12'($urandom);
      #1;
      checkCount++;
      if (busIf.bus_out !== expBus()) begin
        failCount++;
        $display("[TB] FAIL random_follow cycle %0d: bus=%b expected %b",
                 i, busIf.bus_out, expBus());
      end
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b0;
    modelReset();
    test_reset();
    test_idle_gating();
    test_single_source();
    test_rotation();
    test_wrap();
    test_early_release();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mux_bus_arbiter.md
# mux_bus_arbiter

Round-robin arbiter and sequencer for the shared 3-bit result bus built from per-source 2:1 gating muxes, where each mux passes its source when its select bit is high and drives zero otherwise. The block takes bus requests from up to NUM_REQ sources and drives the one-hot select bits that feed those gating muxes. It holds each grant for a bounded number of cycles and inserts a one-cycle turnaround gap between owners. It also produces the OR-combined bus value and a valid flag for the downstream consumer.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 3, bus/data width per requester
- HOLD_CYCLES, 2, maximum consecutive cycles one grant is held (>=1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-source bus request, level-sensitive
- data_in  input  NUM_REQ*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH]
- grant  output  NUM_REQ  one-hot (or zero) select bits, one per gating mux
- bus_out  output  WIDTH  gated bus value: data of granted source, else all zeros
- bus_valid  output  1  high when any grant bit is high
- busy  output  1  high in states HOLD and GAP

## Operation
- States: IDLE, HOLD, GAP. Encoding is free; reset state is IDLE.
- Round-robin pointer `last` (index of most recent owner). Reset value is NUM_REQ-1, so source 0 has first priority after reset.
- IDLE:
  - If any req bit is high, select the first requesting index found searching `last+1`, `last+2`, ... with wrap modulo NUM_REQ.
  - Register grant = one-hot of that index, set `last` to it, load the hold counter with 1, and go to HOLD.
  - If no req bit is high, stay in IDLE with grant = 0.
- HOLD (grant held constant):
  - If the owner's req is low, or the hold counter equals HOLD_CYCLES, clear grant and go to GAP.
  - Otherwise increment the hold counter.
  - Requests from other sources have no effect during HOLD.
- GAP:
  - grant = 0 for exactly one cycle, then go to IDLE.
  - The same edge that enters IDLE does not arbitrate; arbitration happens on the next edge.
- Counter width is clog2(HOLD_CYCLES+1) and must not wrap. The counter is cleared on entry to GAP.
- bus_out is combinational: the bitwise OR over i of (grant[i] ? data_in[i] : 0). It is all zeros when grant = 0, matching the gating-mux behaviour. Because grant is one-hot, no OR conflicts occur.
- bus_valid = |grant. busy = (state != IDLE).
- grant is never more than one-hot. grant is never nonzero in IDLE or GAP.
- reset asserted at any time, including mid-HOLD:
  - Immediately: grant = 0, bus_out = 0, bus_valid = 0, busy = 0.
  - State = IDLE, `last` = NUM_REQ-1, hold counter = 0.

## Timing
- Reset values: grant 0, bus_out 0, bus_valid 0, busy 0.
- Grant latency: req sampled high in IDLE at edge t; grant, bus_valid and busy are high after edge t.
- Maximum ownership: HOLD_CYCLES cycles of grant high, then 1 GAP cycle, then 1 IDLE cycle before the next grant. Back-to-back owners are therefore separated by 2 cycles with grant = 0.
- Early release: owner req low sampled at edge t in HOLD; grant is low after edge t.
- A req that drops in IDLE before it is sampled is never granted. Requests are not latched.
- bus_out follows data_in changes of the granted source within the same cycle, with no register stage.
- Worst-case wait for a continuously requesting source: (NUM_REQ-1)*(HOLD_CYCLES+2) cycles from its first IDLE sample.

## Test plan
- Single source: req=4'b0100 held, HOLD_CYCLES=2, data_in source 2 = 3'b101.
  - Required: grant=0100 for 2 cycles with bus_out=101 and bus_valid=1, then 2 cycles with grant=0 and bus_out=000, then re-granted.
- Rotation: req=4'b1111 held constantly.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 cycles and is separated by 2 zero cycles.
- Wrap-around: req=4'b1001 after reset.
  - Required: source 0 is granted first, then source 3, then source 0. Sources 1 and 2 are never granted.
- Early release: source 1 granted, req[1] dropped after the first HOLD cycle.
  - Required: grant falls after that edge (1 cycle of ownership), GAP follows, and `last`=1 is retained.
- Reset mid-HOLD: assert reset asynchronously while grant=0010.
  - Required: grant, bus_out and bus_valid go to 0 without waiting for a clock edge.
  - After release with req=4'b0011, source 0 is granted first.
- Gating when idle: req=0 with data_in all ones.
  - Required: bus_out=000, bus_valid=0 and busy=0 for every cycle.
